// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for a synchronous single-port memory.
// One transaction in flight at a time; responses return to the granted requester.
module mem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int MEM_RD_LAT = 1,
  parameter int ARB_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,

  output logic              busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_e;

  state_e            state_q;
  logic              last_grant_q;
  logic              id_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              win1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default is how latches get inferred.
  always_comb begin
    win1 = req1_valid;
    if (req0_valid && req1_valid) begin
      win1 = (ARB_MODE == 0) && !last_grant_q;
    end
  end

  assign sel_we    = win1 ? req1_we    : req0_we;
  assign sel_addr  = win1 ? req1_addr  : req0_addr;
  assign sel_wdata = win1 ? req1_wdata : req0_wdata;

  assign req0_ready = (state_q == IDLE) && req0_valid && !win1;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  win1;
  assign busy       = (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp1_rdata   <= '0;
    end else begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          // The memory pins are loaded at accept so the strobe lands in the ACCESS cycle.
          if (req0_ready || req1_ready) begin
            id_q         <= win1;
            we_q         <= sel_we;
            last_grant_q <= win1;
            mem_addr     <= sel_addr;
            mem_write    <= sel_we;
            mem_read     <= !sel_we;
            if (sel_we) mem_data_in <= sel_wdata;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q) begin
            rsp0_valid <= !id_q;
            rsp1_valid <= id_q;
            state_q    <= IDLE;
          end else begin
            cnt_q   <= CNT_W'(MEM_RD_LAT);
            state_q <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            if (id_q) begin
              rsp1_rdata <= mem_data_out;
              rsp1_valid <= 1'b1;
            end else begin
              rsp0_rdata <= mem_data_out;
              rsp0_valid <= 1'b1;
            end
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three configurations (RR/lat1, fixed-priority/lat1, RR/lat3),
// each with a behavioural memory and a transaction-level timing model.
module tb_mem_arbiter;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cur;
  int   checks = 0;
  int   errors = 0;

  logic       v0 [NI], we0 [NI], v1 [NI], we1 [NI];
  logic [4:0] a0 [NI], a1 [NI];
  logic [7:0] d0 [NI], d1 [NI];
  logic       rdy0 [NI], rdy1 [NI], rv0 [NI], rv1 [NI];
  logic       mrd [NI], mwr [NI], bsy [NI];
  logic [4:0] maddr [NI];
  logic [7:0] mdi [NI], mdo [NI], rd0 [NI], rd1 [NI];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t: got %0h expected %0h", tag, cur, $time, got, exp);
    end
  endtask

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int LAT  = (k == 2) ? 3 : 1;
    localparam int MODE = (k == 1) ? 1 : 0;

    mem_arbiter #(.ADDR_W(5), .DATA_W(8), .MEM_RD_LAT(LAT), .ARB_MODE(MODE)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0[k]), .req0_we(we0[k]), .req0_addr(a0[k]), .req0_wdata(d0[k]),
      .req0_ready(rdy0[k]), .rsp0_valid(rv0[k]), .rsp0_rdata(rd0[k]),
      .req1_valid(v1[k]), .req1_we(we1[k]), .req1_addr(a1[k]), .req1_wdata(d1[k]),
      .req1_ready(rdy1[k]), .rsp1_valid(rv1[k]), .rsp1_rdata(rd1[k]),
      .mem_read(mrd[k]), .mem_write(mwr[k]), .mem_addr(maddr[k]),
      .mem_data_in(mdi[k]), .mem_data_out(mdo[k]), .busy(bsy[k])
    );

    // Memory device: read data appears LAT cycles after the strobe is sampled.
    logic [7:0] mem  [32] = '{default: 8'h00};
    logic [7:0] pipe [4]  = '{default: 8'h00};
    always @(posedge clk) begin
      if (mwr[k]) mem[maddr[k]] <= mdi[k];
      if (mrd[k]) pipe[0] <= mem[maddr[k]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mdo[k] = pipe[LAT-1];

    // Transaction-level model: predicts ready, strobes and response timing from
    // the accept cycle and the arbitration rule.
    int         cyc = 0, busy_until = 0, st_cyc = -1, rsp_cyc = -1;
    logic       st_we = 1'b0, rsp_id = 1'b0, rsp_rd = 1'b0, last = 1'b1;
    logic [4:0] st_addr = '0;
    logic [7:0] st_data = '0, rsp_data = '0;
    logic [7:0] exp_rd [2] = '{default: 8'h00};
    logic [7:0] ref_mem [32] = '{default: 8'h00};

    always @(negedge clk) begin
      logic idle, win, e0, e1;
      cyc++;
      if (!rst_n) begin
        busy_until = cyc; st_cyc = -1; rsp_cyc = -1; last = 1'b1;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        if (cur == k)
          check("reset_outputs",
                {rdy0[k], rdy1[k], rv0[k], rv1[k], mrd[k], mwr[k], bsy[k],
                 maddr[k], mdi[k], rd0[k], rd1[k]}, 64'd0);
      end else begin
        idle = (cyc >= busy_until);
        if (v0[k] && v1[k]) win = (MODE == 1) ? 1'b0 : !last;
        else                win = v1[k];
        e0 = idle && v0[k] && !win;
        e1 = idle && v1[k] && win;
        if (cyc == rsp_cyc && rsp_rd) exp_rd[rsp_id] = rsp_data;
        if (cur == k) begin
          check("ready", {rdy0[k], rdy1[k]}, {e0, e1});
          check("busy", bsy[k], !idle);
          check("strobes", {mrd[k], mwr[k]}, {cyc == st_cyc && !st_we, cyc == st_cyc && st_we});
          if (cyc == st_cyc) check("mem_addr", maddr[k], st_addr);
          if (cyc == st_cyc && st_we) check("mem_data_in", mdi[k], st_data);
          check("rsp_valid", {rv0[k], rv1[k]}, {cyc == rsp_cyc && !rsp_id, cyc == rsp_cyc && rsp_id});
          check("rsp0_rdata", rd0[k], exp_rd[0]);
          check("rsp1_rdata", rd1[k], exp_rd[1]);
        end
        if (e0 || e1) begin
          st_cyc     = cyc + 1;
          st_we      = win ? we1[k] : we0[k];
          st_addr    = win ? a1[k]  : a0[k];
          st_data    = win ? d1[k]  : d0[k];
          rsp_id     = win;
          rsp_rd     = !st_we;
          rsp_cyc    = cyc + (st_we ? 2 : 2 + LAT);
          busy_until = rsp_cyc;
          last       = win;
          if (st_we) ref_mem[st_addr] = st_data;
          else       rsp_data = ref_mem[st_addr];
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Presents one request on instance cur; patience>0 abandons it after that many cycles.
  task automatic issue(input int id, input logic we, input logic [4:0] addr,
                       input logic [7:0] data, input int patience);
    int n = 0;
    if (id == 0) begin v0[cur] = 1'b1; we0[cur] = we; a0[cur] = addr; d0[cur] = data; end
    else         begin v1[cur] = 1'b1; we1[cur] = we; a1[cur] = addr; d1[cur] = data; end
    forever begin
      @(negedge clk);
      if (id == 0 ? rdy0[cur] : rdy1[cur]) break;
      n++;
      if (patience > 0 && n >= patience) break;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL handshake_timeout inst=%0d req=%0d: waited %0d cycles, required < 500", cur, id, n);
        break;
      end
    end
    @(posedge clk); #1;
    if (id == 0) v0[cur] = 1'b0; else v1[cur] = 1'b0;
  endtask

  task automatic rand_thread(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      cycles($urandom_range(0, 3));
      issue(id, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom),
            ($urandom_range(0, 4) == 0) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] ra;
    logic [7:0] rdv;
    for (int k = 0; k < NI; k++) begin
      v0[k] = 0; we0[k] = 0; a0[k] = 0; d0[k] = 0;
      v1[k] = 0; we1[k] = 0; a1[k] = 0; d1[k] = 0;
    end
    cur   = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);

    // Clear then read back zeros.
    for (int i = 0; i < 32; i++) issue(0, 1'b1, 5'(i), 8'h00, 0);
    for (int i = 0; i < 32; i++) issue(0, 1'b0, 5'(i), 8'h00, 0);
    cycles(4);

    // Data = address through requester 1.
    for (int i = 0; i < 32; i++) issue(1, 1'b1, 5'(i), 8'(i), 0);
    for (int i = 0; i < 32; i++) issue(1, 1'b0, 5'(i), 8'h00, 0);
    cycles(4);
    check("data_eq_addr_last", rd1[0], 8'd31);

    // Round-robin contention on one address straight after reset.
    do_reset();
    fork
      issue(0, 1'b1, 5'd5, 8'hAA, 0);
      issue(1, 1'b1, 5'd5, 8'h55, 0);
    join
    issue(0, 1'b0, 5'd5, 8'h00, 0);
    cycles(4);
    check("contention_rd", rd0[0], 8'h55);

    // Reset while a read is waiting on memory latency.
    issue(0, 1'b0, 5'd3, 8'h00, 0);
    do_reset();
    fork
      issue(0, 1'b1, 5'd9, 8'h01, 0);
      issue(1, 1'b1, 5'd9, 8'h02, 0);
    join
    cycles(4);

    fork
      rand_thread(0, 60);
      rand_thread(1, 60);
    join
    cycles(8);

    // Fixed priority: requester 1 waits out ten back-to-back requester-0 reads.
    cur = 1;
    cycles(2);
    fork
      for (int i = 0; i < 10; i++) issue(0, 1'b0, 5'(i), 8'h00, 0);
      issue(1, 1'b1, 5'd20, 8'h3C, 0);
    join
    fork
      rand_thread(0, 40);
      rand_thread(1, 40);
    join
    cycles(8);

    // Longer memory latency: write then read back random locations.
    cur = 2;
    cycles(2);
    for (int i = 0; i < 8; i++) begin
      ra  = 5'($urandom_range(0, 31));
      rdv = 8'($urandom);
      issue(0, 1'b1, ra, rdv, 0);
      issue(0, 1'b0, ra, 8'h00, 0);
      cycles(6);
      check("lat3_rd", rd0[2], rdv);
    end
    fork
      rand_thread(0, 40);
      rand_thread(1, 40);
    join
    cycles(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
